// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and ALU operand select.
// Define EX_OPERAND_FWD_EN to compile in the forwarding muxes; otherwise the register-file data is used directly.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  input  logic [DATA_WIDTH-1:0]     i_id_pc,
  input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_id_imm,
  input  logic [SEL_WIDTH-1:0]      i_id_alu_sel,
  input  logic                      i_id_src_a_pc,
  input  logic                      i_id_src_b_imm,
  input  logic                      i_id_reg_write,
  input  logic                      i_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_result,
  input  logic                      i_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_result,
  output logic [DATA_WIDTH-1:0]     o_src_a,
  output logic [DATA_WIDTH-1:0]     o_src_b,
  output logic [SEL_WIDTH-1:0]      o_alu_sel,
  output logic                      o_ex_valid,
  output logic [DATA_WIDTH-1:0]     o_ex_pc,
  output logic [DATA_WIDTH-1:0]     o_ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_reg_write
);

  logic                         vld_p1;
  logic [DATA_WIDTH-1:0]        pc_p1;
  logic signed [DATA_WIDTH-1:0] rs1_data_p1;
  logic signed [DATA_WIDTH-1:0] rs2_data_p1;
  logic [REG_ADDR_WIDTH-1:0]    rs1_addr_p1;
  logic [REG_ADDR_WIDTH-1:0]    rs2_addr_p1;
  logic [REG_ADDR_WIDTH-1:0]    rd_addr_p1;
  logic signed [DATA_WIDTH-1:0] imm_p1;
  logic [SEL_WIDTH-1:0]         alu_sel_p1;
  logic                         src_a_pc_p1;
  logic                         src_b_imm_p1;
  logic                         reg_write_p1;

  logic signed [DATA_WIDTH-1:0] fwd_rs1;
  logic signed [DATA_WIDTH-1:0] fwd_rs2;

  // Stage p0 -> p1: ID/EX register; a bubble carries the same all-zero fields as reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_addr_p1   <= '0;
      imm_p1       <= '0;
      alu_sel_p1   <= '0;
      src_a_pc_p1  <= 1'b0;
      src_b_imm_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
    end else if (!i_stall) begin
      vld_p1       <= i_id_valid;
      pc_p1        <= i_id_pc;
      rs1_data_p1  <= i_id_rs1_data;
      rs2_data_p1  <= i_id_rs2_data;
      rs1_addr_p1  <= i_id_rs1_addr;
      rs2_addr_p1  <= i_id_rs2_addr;
      rd_addr_p1   <= i_id_valid ? i_id_rd_addr : '0;
      imm_p1       <= i_id_imm;
      alu_sel_p1   <= i_id_valid ? i_id_alu_sel : '0;
      src_a_pc_p1  <= i_id_src_a_pc;
      src_b_imm_p1 <= i_id_src_b_imm;
      reg_write_p1 <= i_id_reg_write & i_id_valid;
    end
  end

`ifdef EX_OPERAND_FWD_EN
  // MEM beats WB because it holds the younger result; x0 is hardwired zero and never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_pick(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     rf_data,
    input logic                      mem_we,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic [DATA_WIDTH-1:0]     mem_res,
    input logic                      wb_we,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic [DATA_WIDTH-1:0]     wb_res
  );
    logic [DATA_WIDTH-1:0] r;
    r = rf_data;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs))    r = mem_res;
      else if (wb_we && (wb_rd == rs)) r = wb_res;
    end
    return r;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_pick(rs1_addr_p1, rs1_data_p1, i_mem_reg_write, i_mem_rd_addr,
                       i_mem_result, i_wb_reg_write, i_wb_rd_addr, i_wb_result);
    fwd_rs2 = fwd_pick(rs2_addr_p1, rs2_data_p1, i_mem_reg_write, i_mem_rd_addr,
                       i_mem_result, i_wb_reg_write, i_wb_rd_addr, i_wb_result);
  end
`else
  always_comb begin
    fwd_rs1 = rs1_data_p1;
    fwd_rs2 = rs2_data_p1;
  end

  // Without forwarding the hazard unit stalls every RAW, so these sources go nowhere.
  logic unused_fwd_srcs;
  assign unused_fwd_srcs = ^{i_mem_reg_write, i_mem_rd_addr, i_mem_result,
                             i_wb_reg_write, i_wb_rd_addr, i_wb_result,
                             rs1_addr_p1, rs2_addr_p1};
`endif

  // Stage p1 outputs: operand select feeds the ALU combinationally.
  always_comb begin
    o_src_a         = src_a_pc_p1  ? pc_p1  : fwd_rs1;
    o_src_b         = src_b_imm_p1 ? imm_p1 : fwd_rs2;
    o_ex_store_data = fwd_rs2;
    o_alu_sel       = alu_sel_p1;
    o_ex_valid      = vld_p1;
    o_ex_pc         = pc_p1;
    o_ex_rd_addr    = rd_addr_p1;
    o_ex_reg_write  = reg_write_p1 & vld_p1;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage; follows EX_OPERAND_FWD_EN to pick forwarded or register-file expectations.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_id_valid;
  logic [31:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic [3:0]  i_id_alu_sel;
  logic        i_id_src_a_pc, i_id_src_b_imm, i_id_reg_write;
  logic        i_mem_reg_write, i_wb_reg_write;
  logic [4:0]  i_mem_rd_addr, i_wb_rd_addr;
  logic [31:0] i_mem_result, i_wb_result;
  logic [31:0] o_src_a, o_src_b, o_ex_pc, o_ex_store_data;
  logic [3:0]  o_alu_sel;
  logic        o_ex_valid, o_ex_reg_write;
  logic [4:0]  o_ex_rd_addr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 i_clk = ~i_clk;

  ex_operand_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_imm(i_id_imm), .i_id_alu_sel(i_id_alu_sel),
    .i_id_src_a_pc(i_id_src_a_pc), .i_id_src_b_imm(i_id_src_b_imm),
    .i_id_reg_write(i_id_reg_write),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_result(i_mem_result),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_result(i_wb_result),
    .o_src_a(o_src_a), .o_src_b(o_src_b), .o_alu_sel(o_alu_sel), .o_ex_valid(o_ex_valid),
    .o_ex_pc(o_ex_pc), .o_ex_store_data(o_ex_store_data), .o_ex_rd_addr(o_ex_rd_addr),
    .o_ex_reg_write(o_ex_reg_write)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rst = 0; i_stall = 0; i_flush = 0; i_id_valid = 0;
    i_id_pc = 0; i_id_rs1_data = 0; i_id_rs2_data = 0; i_id_imm = 0;
    i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_rd_addr = 0; i_id_alu_sel = 0;
    i_id_src_a_pc = 0; i_id_src_b_imm = 0; i_id_reg_write = 0;
    i_mem_reg_write = 0; i_mem_rd_addr = 0; i_mem_result = 0;
    i_wb_reg_write = 0; i_wb_rd_addr = 0; i_wb_result = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; i_id_valid = 1; i_id_reg_write = 1;
    i_id_pc = $urandom; i_id_rs1_data = $urandom; i_id_rs2_data = $urandom;
    i_id_imm = $urandom; i_id_alu_sel = 4'($urandom_range(1, 15));
    i_id_rd_addr = 5'($urandom_range(1, 31));
    step();
    n_vec++; if (o_ex_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %0b want 0", o_ex_valid); end
    n_vec++; if (o_ex_reg_write !== 1'b0) begin n_miss++; $display("FAIL reset_regwr got %0b want 0", o_ex_reg_write); end
    n_vec++; if (o_alu_sel !== 4'b0000) begin n_miss++; $display("FAIL reset_alusel got %b want 0000", o_alu_sel); end
    n_vec++; if (o_ex_pc !== 32'h0) begin n_miss++; $display("FAIL reset_pc got %h want 0", o_ex_pc); end
    n_vec++; if (o_ex_rd_addr !== 5'd0) begin n_miss++; $display("FAIL reset_rd got %0d want 0", o_ex_rd_addr); end
    n_vec++; if (o_src_a !== 32'h0 || o_src_b !== 32'h0 || o_ex_store_data !== 32'h0) begin
      n_miss++; $display("FAIL reset_operands got %h/%h/%h want 0/0/0", o_src_a, o_src_b, o_ex_store_data);
    end
    idle_inputs();
  endtask

  task automatic test_plain_load();
    i_id_valid = 1; i_id_rs1_data = 5; i_id_rs2_data = 7; i_id_alu_sel = 4'b0001;
    i_id_rs1_addr = 1; i_id_rs2_addr = 2; i_id_rd_addr = 9; i_id_reg_write = 1; i_id_pc = 32'h40;
    step();
    n_vec++; if (o_src_a !== 32'd5) begin n_miss++; $display("FAIL load_src_a got %h want 5", o_src_a); end
    n_vec++; if (o_src_b !== 32'd7) begin n_miss++; $display("FAIL load_src_b got %h want 7", o_src_b); end
    n_vec++; if (o_alu_sel !== 4'b0001) begin n_miss++; $display("FAIL load_alusel got %b want 0001", o_alu_sel); end
    n_vec++; if (o_ex_valid !== 1'b1) begin n_miss++; $display("FAIL load_valid got %0b want 1", o_ex_valid); end
    n_vec++; if (o_ex_rd_addr !== 5'd9 || o_ex_reg_write !== 1'b1 || o_ex_pc !== 32'h40) begin
      n_miss++; $display("FAIL load_ctrl got rd=%0d we=%0b pc=%h want rd=9 we=1 pc=40", o_ex_rd_addr, o_ex_reg_write, o_ex_pc);
    end
    // Invalid slot: rd/alu_sel/reg_write forced to zero, pc still captured.
    i_id_valid = 0; i_id_pc = 32'h44; i_id_alu_sel = 4'b0110; i_id_rd_addr = 12; i_id_reg_write = 1;
    step();
    n_vec++; if (o_ex_valid !== 1'b0 || o_ex_rd_addr !== 5'd0 || o_alu_sel !== 4'd0 || o_ex_reg_write !== 1'b0 || o_ex_pc !== 32'h44) begin
      n_miss++; $display("FAIL invalid_load got v=%0b rd=%0d sel=%b we=%0b pc=%h want 0/0/0000/0/44",
                         o_ex_valid, o_ex_rd_addr, o_alu_sel, o_ex_reg_write, o_ex_pc);
    end
    idle_inputs();
  endtask

  task automatic test_forward_priority();
    logic [31:0] exp;
    i_id_valid = 1; i_id_rs1_addr = 3; i_id_rs1_data = 32'h11;
    step();
    i_mem_reg_write = 1; i_mem_rd_addr = 3; i_mem_result = 32'hAA;
    i_wb_reg_write = 1;  i_wb_rd_addr = 3;  i_wb_result = 32'hBB;
    #1;
    exp = FWD ? 32'hAA : 32'h11;
    n_vec++; if (o_src_a !== exp) begin n_miss++; $display("FAIL fwd_mem_over_wb got %h want %h", o_src_a, exp); end
    i_mem_reg_write = 0;
    #1;
    exp = FWD ? 32'hBB : 32'h11;
    n_vec++; if (o_src_a !== exp) begin n_miss++; $display("FAIL fwd_wb got %h want %h", o_src_a, exp); end
    // Matching address but write disabled on both sources.
    i_wb_reg_write = 0;
    #1;
    n_vec++; if (o_src_a !== 32'h11) begin n_miss++; $display("FAIL fwd_none got %h want 11", o_src_a); end
    i_id_rs1_addr = 0; i_id_rs1_data = 32'h22;
    i_mem_reg_write = 1; i_mem_rd_addr = 0; i_wb_reg_write = 1; i_wb_rd_addr = 0;
    step();
    n_vec++; if (o_src_a !== 32'h22) begin n_miss++; $display("FAIL fwd_x0 got %h want 22", o_src_a); end
    idle_inputs();
  endtask

  task automatic test_imm_pc_select();
    logic [31:0] exp;
    i_id_valid = 1; i_id_src_a_pc = 1; i_id_src_b_imm = 1;
    i_id_pc = 32'h100; i_id_imm = 32'hFFFF_FFFC;
    i_id_rs1_addr = 6; i_id_rs1_data = 32'h77; i_id_rs2_addr = 4; i_id_rs2_data = 32'h66;
    i_mem_reg_write = 1; i_mem_rd_addr = 4; i_mem_result = 32'h55;
    step();
    exp = FWD ? 32'h55 : 32'h66;
    n_vec++; if (o_src_a !== 32'h100) begin n_miss++; $display("FAIL sel_pc got %h want 100", o_src_a); end
    n_vec++; if (o_src_b !== 32'hFFFF_FFFC) begin n_miss++; $display("FAIL sel_imm got %h want fffffffc", o_src_b); end
    n_vec++; if (o_ex_store_data !== exp) begin n_miss++; $display("FAIL store_data got %h want %h", o_ex_store_data, exp); end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    i_id_valid = 1; i_id_pc = 32'h200; i_id_rd_addr = 7; i_id_alu_sel = 4'b0011;
    i_id_reg_write = 1; i_id_rs1_data = 32'h1234;
    step();
    i_stall = 1; i_id_pc = 32'h300; i_id_rd_addr = 8; i_id_alu_sel = 4'b1000;
    i_id_rs1_data = 32'h9999; i_id_valid = 0;
    step();
    i_id_pc = 32'h304; i_id_rd_addr = 10;
    step();
    n_vec++; if (o_ex_pc !== 32'h200 || o_ex_rd_addr !== 5'd7 || o_alu_sel !== 4'b0011) begin
      n_miss++; $display("FAIL stall_hold got pc=%h rd=%0d sel=%b want 200/7/0011", o_ex_pc, o_ex_rd_addr, o_alu_sel);
    end
    n_vec++; if (o_ex_valid !== 1'b1 || o_ex_reg_write !== 1'b1 || o_src_a !== 32'h1234) begin
      n_miss++; $display("FAIL stall_hold_v got v=%0b we=%0b a=%h want 1/1/1234", o_ex_valid, o_ex_reg_write, o_src_a);
    end
    i_flush = 1; i_id_valid = 1;
    step();
    n_vec++; if (o_ex_valid !== 1'b0 || o_ex_reg_write !== 1'b0 || o_ex_pc !== 32'h0 || o_ex_rd_addr !== 5'd0) begin
      n_miss++; $display("FAIL stall_flush got v=%0b we=%0b pc=%h rd=%0d want 0/0/0/0", o_ex_valid, o_ex_reg_write, o_ex_pc, o_ex_rd_addr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    i_id_valid = 1; i_id_pc = 32'h500; i_id_rd_addr = 3; i_id_reg_write = 1; i_id_alu_sel = 4'b0101;
    step();
    i_stall = 1;
    step();
    i_rst = 1;
    step();
    n_vec++; if (o_ex_valid !== 1'b0 || o_ex_pc !== 32'h0 || o_alu_sel !== 4'd0 || o_ex_reg_write !== 1'b0) begin
      n_miss++; $display("FAIL reset_mid_stall got v=%0b pc=%h sel=%b we=%0b want 0/0/0000/0", o_ex_valid, o_ex_pc, o_alu_sel, o_ex_reg_write);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    step();
    test_reset();
    test_plain_load();
    test_forward_priority();
    test_imm_pc_select();
    test_stall_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage of the 5-stage RISC-V core. It captures decoded instruction fields at the end of Decode and holds them for Execute. It resolves RAW hazards by forwarding results from the MEM and WB stages. It presents the final ALU operands and ALU select directly to the execute-stage ALU, and passes store data and writeback control downstream.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- SEL_WIDTH, 4, ALU select width (encoding owned by the ALU; 0000 = add)
- REG_ADDR_WIDTH, 5, register index width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hold all ID/EX state
- i_flush  in  1  load a bubble on next edge
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_pc  in  DATA_WIDTH  instruction PC
- i_id_rs1_data, i_id_rs2_data  in  DATA_WIDTH  register-file read data
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  REG_ADDR_WIDTH  register indices
- i_id_imm  in  DATA_WIDTH  sign-extended immediate
- i_id_alu_sel  in  SEL_WIDTH  ALU operation
- i_id_src_a_pc  in  1  operand A = PC instead of rs1
- i_id_src_b_imm  in  1  operand B = immediate instead of rs2
- i_id_reg_write  in  1  instruction writes rd
- i_mem_reg_write, i_mem_rd_addr, i_mem_result  in  1/REG_ADDR_WIDTH/DATA_WIDTH  MEM-stage writeback source
- i_wb_reg_write, i_wb_rd_addr, i_wb_result  in  1/REG_ADDR_WIDTH/DATA_WIDTH  WB-stage writeback source
- o_src_a, o_src_b  out  DATA_WIDTH  ALU operands
- o_alu_sel  out  SEL_WIDTH  ALU select
- o_ex_valid  out  1  EX slot valid
- o_ex_pc  out  DATA_WIDTH  registered PC
- o_ex_store_data  out  DATA_WIDTH  forwarded rs2 value, independent of src_b_imm
- o_ex_rd_addr  out  REG_ADDR_WIDTH  destination
- o_ex_reg_write  out  1  destination write enable, gated by valid

## Operation
- Register update priority each edge is i_rst > i_flush > i_stall > load.
- **Reset:** every register cleared to 0.
  - o_ex_valid = 0, o_ex_reg_write = 0, o_ex_rd_addr = 0, o_alu_sel = 0000, o_ex_pc = 0.
  - With forwarding sources idle, o_src_a = o_src_b = o_ex_store_data = 0.
- **Flush:** loads a bubble with the same field values as reset. Flush wins over a simultaneous stall.
- **Stall:** all registers hold. Forwarding muxes remain live, so operands may change if MEM/WB change.
- **Load:** all i_id_* fields are captured. The stored reg_write is i_id_reg_write & i_id_valid. When i_id_valid = 0, the stored rd_addr and alu_sel are forced to 0.
- **Forwarding (combinational, from registered rs1/rs2 addr), per source operand:**
  - If i_mem_reg_write, i_mem_rd_addr == rsX, and rsX != 0: use i_mem_result.
  - Otherwise, if the same conditions hold for WB: use i_wb_result.
  - Otherwise: use the registered rsX data.
  - MEM has priority over WB. Register x0 is never forwarded.
- **Operand select:**
  - o_src_a = src_a_pc ? pc : fwd_rs1
  - o_src_b = src_b_imm ? imm : fwd_rs2
  - o_ex_store_data = fwd_rs2 always.
- Forwarding is applied regardless of o_ex_valid; downstream qualifies by valid.

## Timing
- Decode-to-EX latency is one cycle: values presented at edge N appear on the o_ex_* outputs after edge N.
- MEM/WB to o_src_a, o_src_b and o_ex_store_data is a purely combinational path, with zero-cycle latency.
- A flush asserted in cycle N yields o_ex_valid = 0 after edge N.
- A stall asserted in cycle N keeps all registered outputs unchanged across edge N.
- Reset asserted mid-stall or mid-flush clears state on the next edge.

## Configuration
- Macro: EX_OPERAND_FWD_EN.
- **Defined:** forwarding logic is compiled in, as described above.
- **Undefined:** forwarding muxes are removed.
  - fwd_rs1 and fwd_rs2 are the registered register-file data.
  - All i_mem_* and i_wb_* inputs are ignored.
  - The hazard unit must stall on every RAW dependency.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert i_rst for one edge with random inputs -> o_ex_valid=0, o_ex_reg_write=0, o_alu_sel=0000, o_ex_pc=0.
- Plain load: rs1_data=5, rs2_data=7, alu_sel=0001, no forwarding -> after one edge o_src_a=5, o_src_b=7, o_alu_sel=0001, o_ex_valid=1.
- Forward priority: rs1=3; MEM writes x3=0xAA and WB writes x3=0xBB -> o_src_a=0xAA. Remove MEM -> o_src_a=0xBB. Set rs1=0 with MEM rd=0 -> registered data used.
- Immediate/PC select: src_a_pc=1, src_b_imm=1, pc=0x100, imm=0xFFFFFFFC, MEM forwarding rs2=0x55 -> o_src_a=0x100, o_src_b=0xFFFFFFFC, o_ex_store_data=0x55.
- Stall then flush: load an instruction, then stall 2 cycles while changing i_id_* -> outputs held. Assert stall and flush together -> o_ex_valid=0, o_ex_reg_write=0.
- Without EX_OPERAND_FWD_EN: MEM writes x3=0xAA with rs1=3 and rs1_data=0x11 -> o_src_a=0x11.
